// File: rtl/m_tx.sv
// m_tx: byte-serial packet source to 64-bit word stream with sop/eop/length
// framing, minimum inter-packet gap and maximum packet length enforcement.

package m_pkg;
   // One word of the matcher ingress stream; data is little-endian by byte.
   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [3:0]  length;
      logic [63:0] data;
   } in_t;
endpackage

module m_tx #(
   parameter int unsigned IPG_CYCLES = 1,
   parameter int unsigned MAX_WORDS  = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         byte_vld_w,
   input  logic [7:0]   byte_w,
   input  logic         byte_last_w,
   output logic         byte_rdy_r,
   output logic         out_vld_r,
   output m_pkg::in_t   out_r,
   output logic [15:0]  pkt_cnt_r,
   output logic         trunc_r
);

   localparam int unsigned WCW      = $clog2(MAX_WORDS) + 1;
   localparam int unsigned GCW      = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
   localparam int unsigned GAP_LOAD = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN,
      S_GAP
   } state_e;

   state_e           state_q, state_d;
   logic             rdy_q, rdy_d;
   logic             vld_q, vld_d;
   m_pkg::in_t       out_q, out_d;
   logic [15:0]      pkt_q, pkt_d;
   logic             trunc_q, trunc_d;
   logic [2:0]       idx_q, idx_d;
   logic [63:0]      acc_q, acc_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic             first_q, first_d;
   logic [GCW-1:0]   gap_q, gap_d;

   logic             accept;
   logic [63:0]      word_data;
   logic             is_sop;
   logic [WCW-1:0]   word_num;
   logic             cut;
   logic             word_done;

   // Next-state, packing and framing logic.
   always_comb begin
      state_d = state_q;
      rdy_d   = rdy_q;
      vld_d   = 1'b0;
      out_d   = out_q;
      pkt_d   = pkt_q;
      trunc_d = trunc_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      wcnt_d  = wcnt_q;
      first_d = first_q;
      gap_d   = gap_q;

      accept    = byte_vld_w & rdy_q;
      word_data = acc_q | (64'(byte_w) << {idx_q, 3'b000});
      is_sop    = (state_q == S_IDLE) | first_q;
      word_num  = is_sop ? WCW'(1) : wcnt_q + WCW'(1);
      cut       = (word_num == WCW'(MAX_WORDS)) & ~byte_last_w;
      word_done = (idx_q == 3'd7) | byte_last_w;

      case (state_q)
         S_IDLE, S_FILL: begin
            if (accept) begin
               if (word_done) begin
                  vld_d        = 1'b1;
                  out_d.sop    = is_sop;
                  out_d.eop    = byte_last_w | cut;
                  out_d.length = 4'(idx_q) + 4'd1;
                  out_d.data   = word_data;
                  wcnt_d       = word_num;
                  idx_d        = 3'd0;
                  acc_d        = 64'd0;
                  first_d      = 1'b0;
                  if (byte_last_w | cut) begin
                     pkt_d = pkt_q + 16'd1;
                  end
                  if (cut) begin
                     trunc_d = 1'b1;
                     state_d = S_DRAIN;
                  end else if (byte_last_w) begin
                     if (IPG_CYCLES == 0) begin
                        state_d = S_IDLE;
                     end else begin
                        state_d = S_GAP;
                        gap_d   = GCW'(GAP_LOAD);
                     end
                  end else begin
                     state_d = S_FILL;
                  end
               end else begin
                  idx_d   = idx_q + 3'd1;
                  acc_d   = word_data;
                  state_d = S_FILL;
                  if (state_q == S_IDLE) begin
                     first_d = 1'b1;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (accept && byte_last_w) begin
               if (IPG_CYCLES == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GAP;
                  gap_d   = GCW'(GAP_LOAD);
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - GCW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      rdy_d = (state_d != S_GAP);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
         out_q   <= '0;
         pkt_q   <= 16'd0;
         trunc_q <= 1'b0;
         idx_q   <= 3'd0;
         acc_q   <= 64'd0;
         wcnt_q  <= '0;
         first_q <= 1'b0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         vld_q   <= vld_d;
         out_q   <= out_d;
         pkt_q   <= pkt_d;
         trunc_q <= trunc_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         wcnt_q  <= wcnt_d;
         first_q <= first_d;
         gap_q   <= gap_d;
      end
   end

   assign byte_rdy_r = rdy_q;
   assign out_vld_r  = vld_q;
   assign out_r      = out_q;
   assign pkt_cnt_r  = pkt_q;
   assign trunc_r    = trunc_q;

endmodule

// File: tb/tb_m_tx.sv
// tb_m_tx: three m_tx instances (different gap / max-length settings) share one
// byte stream; a per-instance behavioural model is compared every cycle, and
// directed scenarios pin the model with literal expectations.

module tb_m_tx;

   logic        clk;
   logic        rst;
   logic        tb_vld;
   logic [7:0]  tb_byte;
   logic        tb_last;

   logic        d_rdy   [3];
   logic        d_vld   [3];
   m_pkg::in_t  d_out   [3];
   logic [15:0] d_pkt   [3];
   logic        d_trunc [3];

   int ipg_p  [3] = '{1, 3, 0};
   int maxw_p [3] = '{256, 256, 2};

   m_tx #(.IPG_CYCLES(1), .MAX_WORDS(256)) u_dut0 (
      .clk(clk), .rst(rst), .byte_vld_w(tb_vld), .byte_w(tb_byte), .byte_last_w(tb_last),
      .byte_rdy_r(d_rdy[0]), .out_vld_r(d_vld[0]), .out_r(d_out[0]),
      .pkt_cnt_r(d_pkt[0]), .trunc_r(d_trunc[0]));

   m_tx #(.IPG_CYCLES(3), .MAX_WORDS(256)) u_dut1 (
      .clk(clk), .rst(rst), .byte_vld_w(tb_vld), .byte_w(tb_byte), .byte_last_w(tb_last),
      .byte_rdy_r(d_rdy[1]), .out_vld_r(d_vld[1]), .out_r(d_out[1]),
      .pkt_cnt_r(d_pkt[1]), .trunc_r(d_trunc[1]));

   m_tx #(.IPG_CYCLES(0), .MAX_WORDS(2)) u_dut2 (
      .clk(clk), .rst(rst), .byte_vld_w(tb_vld), .byte_w(tb_byte), .byte_last_w(tb_last),
      .byte_rdy_r(d_rdy[2]), .out_vld_r(d_vld[2]), .out_r(d_out[2]),
      .pkt_cnt_r(d_pkt[2]), .trunc_r(d_trunc[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Expected outputs and packet-level model state per instance.
   logic        m_rdy   [3];
   logic        m_vld   [3];
   m_pkg::in_t  m_out   [3];
   logic [15:0] m_pkt   [3];
   logic        m_trunc [3];
   int          nb      [3];
   logic [63:0] wdata   [3];
   int          wcount  [3];
   bit          drain   [3];
   int          gap_left[3];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      bit cut;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_rdy[i] = 1'b0; m_vld[i] = 1'b0; m_out[i] = '0; m_pkt[i] = 16'd0;
            m_trunc[i] = 1'b0; nb[i] = 0; wdata[i] = 64'd0; wcount[i] = 0;
            drain[i] = 1'b0; gap_left[i] = 0;
         end else begin
            m_vld[i] = 1'b0;
            if (!m_rdy[i] && gap_left[i] > 0) begin
               gap_left[i]--;
            end else if (tb_vld && m_rdy[i]) begin
               if (drain[i]) begin
                  if (tb_last) begin
                     drain[i] = 1'b0;
                     gap_left[i] = ipg_p[i];
                  end
               end else begin
                  wdata[i] = wdata[i] | (64'(tb_byte) << (8 * nb[i]));
                  nb[i]++;
                  if (nb[i] == 8 || tb_last) begin
                     cut = (wcount[i] + 1 == maxw_p[i]) && !tb_last;
                     m_out[i].sop    = (wcount[i] == 0);
                     m_out[i].eop    = tb_last || cut;
                     m_out[i].length = 4'(nb[i]);
                     m_out[i].data   = wdata[i];
                     m_vld[i] = 1'b1;
                     wcount[i]++;
                     if (m_out[i].eop) begin
                        m_pkt[i] = m_pkt[i] + 16'd1;
                        wcount[i] = 0;
                     end
                     if (cut) begin
                        m_trunc[i] = 1'b1;
                        drain[i] = 1'b1;
                     end else if (tb_last) begin
                        gap_left[i] = ipg_p[i];
                     end
                     nb[i] = 0;
                     wdata[i] = 64'd0;
                  end
               end
            end
            m_rdy[i] = (gap_left[i] == 0);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input bit v, input logic [7:0] b, input bit l);
      tb_vld = v; tb_byte = b; tb_last = l;
      tick();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 1'b0);
   endtask

   // Per-cycle comparison of every instance against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
               chk($sformatf("rdy%0d", i),   128'(d_rdy[i]),   128'(m_rdy[i]));
               chk($sformatf("vld%0d", i),   128'(d_vld[i]),   128'(m_vld[i]));
               chk($sformatf("out%0d", i),   128'(d_out[i]),   128'(m_out[i]));
               chk($sformatf("pkt%0d", i),   128'(d_pkt[i]),   128'(m_pkt[i]));
               chk($sformatf("trunc%0d", i), 128'(d_trunc[i]), 128'(m_trunc[i]));
            end
         end
      end
   end

   logic [5:0] vld_pat;
   logic [5:0] rdy_pat;

   initial begin
      rst = 1'b1; tb_vld = 1'b0; tb_byte = 8'h00; tb_last = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_rdy", 128'(d_rdy[0]), 128'd0);
      chk("rst_vld", 128'(d_vld[0]), 128'd0);
      chk("rst_out", 128'(d_out[0]), 128'd0);
      chk("rst_pkt", 128'(d_pkt[0]), 128'd0);
      chk("rst_trunc", 128'(d_trunc[0]), 128'd0);
      rst = 1'b0;
      tick();
      chk("rdy_after_rst", 128'(d_rdy[0]), 128'd1);
      idle(2);

      // 1-byte packet on instance 0 (gap 1).
      drive(1'b1, 8'hA5, 1'b1);
      tb_vld = 1'b0;
      chk("p1_vld", 128'(d_vld[0]), 128'd1);
      chk("p1_out", 128'(d_out[0]), {58'd0, 1'b1, 1'b1, 4'd1, 64'h00000000000000A5});
      chk("p1_rdy_low", 128'(d_rdy[0]), 128'd0);
      chk("p1_pkt", 128'(d_pkt[0]), 128'd1);
      idle(1);
      chk("p1_rdy_back", 128'(d_rdy[0]), 128'd1);
      chk("p1_vld_pulse", 128'(d_vld[0]), 128'd0);
      idle(5);

      // 9-byte packet back-to-back.
      for (int k = 1; k <= 9; k++) begin
         drive(1'b1, 8'(k), k == 9);
         if (k == 8) begin
            chk("p9_w0_vld", 128'(d_vld[0]), 128'd1);
            chk("p9_w0", 128'(d_out[0]), {58'd0, 1'b1, 1'b0, 4'd8, 64'h0807060504030201});
         end else if (k == 9) begin
            chk("p9_w1_vld", 128'(d_vld[0]), 128'd1);
            chk("p9_w1", 128'(d_out[0]), {58'd0, 1'b0, 1'b1, 4'd1, 64'h0000000000000009});
         end else begin
            chk("p9_novld", 128'(d_vld[0]), 128'd0);
         end
      end
      idle(6);

      // Stalled source: valid every other cycle, 8 bytes.
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 8'(8'h30 + k), k == 7);
         chk("stall_vld", 128'(d_vld[0]), 128'(k == 7));
         if (k == 7)
            chk("stall_out", 128'(d_out[0]), {58'd0, 1'b1, 1'b1, 4'd8, 64'h3736353433323130});
         drive(1'b0, 8'hEE, 1'b1);
         chk("stall_gap_vld", 128'(d_vld[0]), 128'd0);
      end
      idle(6);

      // Inter-packet gap on instance 1 (gap 3), 1-byte packets offered continuously.
      vld_pat = '0;
      rdy_pat = '0;
      for (int c = 0; c < 6; c++) begin
         drive(1'b1, 8'(c), 1'b1);
         vld_pat[c] = d_vld[1];
         rdy_pat[c] = d_rdy[1];
         if (c == 4)
            chk("ipg_w1", 128'(d_out[1]), {58'd0, 1'b1, 1'b1, 4'd1, 64'h0000000000000004});
      end
      chk("ipg_vld_pattern", 128'(vld_pat), 128'(6'b010001));
      chk("ipg_rdy_pattern", 128'(rdy_pat), 128'(6'b001000));
      idle(8);

      // Truncation on instance 2 (max 2 words) after a clean reset.
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(2);
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, 8'(k), k == 20);
         if (k == 8)
            chk("tr_w0", 128'(d_out[2]), {58'd0, 1'b1, 1'b0, 4'd8, 64'h0807060504030201});
         if (k == 16) begin
            chk("tr_w1_vld", 128'(d_vld[2]), 128'd1);
            chk("tr_w1", 128'(d_out[2]), {58'd0, 1'b0, 1'b1, 4'd8, 64'h100F0E0D0C0B0A09});
            chk("tr_flag", 128'(d_trunc[2]), 128'd1);
            chk("tr_pkt", 128'(d_pkt[2]), 128'd1);
         end
         if (k > 16) begin
            chk("tr_drain_novld", 128'(d_vld[2]), 128'd0);
            chk("tr_drain_rdy", 128'(d_rdy[2]), 128'd1);
         end
      end
      chk("tr_pkt_end", 128'(d_pkt[2]), 128'd1);
      idle(6);

      // Reset mid-packet.
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 8'(8'h50 + k), 1'b0);
         chk("mid_novld", 128'(d_vld[0]), 128'd0);
      end
      tb_vld = 1'b0;
      rst = 1'b1;
      tick();
      chk("mid_rst_rdy", 128'(d_rdy[0]), 128'd0);
      chk("mid_rst_out", 128'(d_out[0]), 128'd0);
      chk("mid_rst_pkt", 128'(d_pkt[0]), 128'd0);
      chk("mid_rst_trunc", 128'(d_trunc[2]), 128'd0);
      tick();
      rst = 1'b0;
      idle(1);
      for (int k = 1; k <= 3; k++) drive(1'b1, 8'(8'hC0 + k), k == 3);
      chk("mid_next_sop", 128'(d_out[0]), {58'd0, 1'b1, 1'b1, 4'd3, 64'h0000000000C3C2C1});
      idle(6);

      // Randomized traffic, with rare resets.
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 1499) == 0);
         drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0);
      end
      rst = 1'b0;
      idle(10);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/m_tx.md
# m_tx

Packet transmitter for the 8B-word ingress stream consumed by the packet matcher (`m`). Accepts a byte-serial packet source over a valid/ready handshake, packs bytes little-endian into 64-bit words, and drives the `in_vld_w`/`in_w` stream with correct `sop`/`eop`/`length` framing. It also enforces a minimum inter-packet gap and a maximum packet length.

## Interface

**Parameters**
- `IPG_CYCLES`, default 1: minimum idle cycles inserted after every `eop` word; 0 is legal.
- `MAX_WORDS`, default 256: maximum words per emitted packet; legal range ≥1.

**Ports**
- `clk`  input  1  clock; single clock domain.
- `rst`  input  1  reset; synchronous, active-high.
- `byte_vld_w`  input  1  source byte valid.
- `byte_w`  input  8  source byte.
- `byte_last_w`  input  1  byte is the final byte of its packet.
- `byte_rdy_r`  output  1  block accepts a byte this cycle; registered.
- `out_vld_r`  output  1  word valid; connects to the matcher's `in_vld_w`.
- `out_r`  output  `m_pkg::in_t`  word; connects to the matcher's `in_w`. Fields:
  - `sop`, `eop`
  - `length`: valid bytes in the word, 1..8, 4 bits
  - `data[63:0]`
- `pkt_cnt_r`  output  16  count of emitted `eop` words; wraps at 2^16.
- `trunc_r`  output  1  sticky; set when any packet is truncated.

## Operation

- Accept: a byte is accepted when `byte_vld_w & byte_rdy_r`.
- Packing:
  - The k-th accepted byte of a word is placed at `data[8k+7:8k]`, k = 0..7.
  - Bytes not filled are driven to zero.
- Word emission: a word is emitted when its 8th byte is accepted, or when a byte with `byte_last_w` is accepted.
- Framing:
  - `length` = bytes in the word.
  - `sop` = 1 on the first word of a packet.
  - `eop` = 1 on the word holding the last byte.
  - A single-word packet has `sop = eop = 1`.
- Word counter `word_cnt` (width clog2(MAX_WORDS)+1):
  - Reset to 0 on every `sop` word.
  - Increments on every emitted word.
- Truncation:
  - If word number `MAX_WORDS` is emitted without last, that word is forced `eop = 1`.
  - `trunc_r` is set.
  - The FSM enters DRAIN.
- FSM states:
  - **IDLE**: no partial word and no packet open. First accepted byte → FILL. If that byte has `byte_last_w`, emit a 1-byte `sop`/`eop` word, then → GAP (or stay IDLE if `IPG_CYCLES = 0`).
  - **FILL**: packet open. Accepting the 8th byte emits the word and stays in FILL. Accepting a last byte emits `eop` and → GAP/IDLE. A truncation word → DRAIN.
  - **DRAIN**: accepts and discards bytes; no output. On the last byte → GAP/IDLE.
  - **GAP**: `byte_rdy_r = 0`. The gap counter loads `IPG_CYCLES-1` on entry, decrements each cycle, and → IDLE at 0.
- `byte_rdy_r` = 1 in IDLE, FILL, and DRAIN. It is 0 in GAP and during reset.
- `pkt_cnt_r` increments on every emitted `eop` word, including truncated ones.

## Timing

- Reset values:
  - `out_vld_r` = 0, `out_r` = all-zero, `byte_rdy_r` = 0.
  - `pkt_cnt_r` = 0, `trunc_r` = 0, state = IDLE.
  - `byte_rdy_r` rises the first cycle after `rst` deasserts.
- Latency:
  - `out_vld_r` and `out_r` are asserted in the cycle after the completing byte is accepted.
  - `out_vld_r` is a single-cycle pulse per word.
  - `out_r` holds its value when `out_vld_r` = 0.
- Throughput: at most one word per 8 cycles mid-packet. There is no downstream backpressure; emitted words are never stalled.
- `byte_vld_w` gaps are legal anywhere. The partial word is held indefinitely.
- Gap timing:
  - `byte_rdy_r` falls in the cycle after the last byte is accepted (coincident with the `eop` word).
  - It stays low for exactly `IPG_CYCLES` cycles.
  - The next `sop` word is therefore emitted no earlier than `IPG_CYCLES+1` cycles after the previous `eop` word.
- `byte_last_w` is ignored unless the byte is accepted.
- Reset mid-packet: the partial word is discarded and no `eop` is emitted. `pkt_cnt_r` and `trunc_r` clear.
- `pkt_cnt_r` updates in the same cycle as the `eop` `out_vld_r`. `trunc_r` sets in the same cycle as the truncated word.

## Test plan

- **1-byte packet**, 0xA5 with last, `IPG_CYCLES` = 1 → one word: `sop = 1`, `eop = 1`, `length = 1`, `data = 0x..00A5`. Then `byte_rdy_r` low for 1 cycle, and `pkt_cnt_r` = 1.
- **9-byte packet**, bytes 0x01..0x09 back-to-back:
  - Word 0: `sop = 1`, `eop = 0`, `length = 8`, `data = 0x0807060504030201`, on the cycle after byte 8.
  - Word 1: `sop = 0`, `eop = 1`, `length = 1`, `data = 0x09`.
- **Stalled source**: 8-byte packet with `byte_vld_w` toggling every other cycle → a single word, `length = 8`, `eop = 1`, emitted 1 cycle after the 8th accept. No spurious `out_vld_r`.
- **Inter-packet gap**: `IPG_CYCLES` = 3, two 1-byte packets offered continuously → `out_vld_r` pulses exactly 4 cycles apart. `byte_rdy_r` is low for 3 cycles between them.
- **Truncation**: `MAX_WORDS` = 2, 20-byte packet:
  - Two words emitted; the second has `eop = 1`, `length = 8`.
  - `trunc_r` = 1.
  - Bytes 17–20 are accepted with no output.
  - `pkt_cnt_r` = 1.
- **Reset mid-packet**: `rst` asserted after 5 bytes of a 12-byte packet → no output word. All outputs return to reset values, and the next packet starts with `sop = 1`.
